// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package adder_pkg;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned SUM_W = WIDTH + 1;
endpackage

// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for four_bit_adder; master drives operands, slave returns the sum.
interface four_bit_adder_if #(
  parameter int unsigned WIDTH = adder_pkg::WIDTH
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic [WIDTH:0]   sum;
  logic             out_valid;

  modport master (
    output A,
    output B,
    output in_valid,
    input  sum,
    input  out_valid
  );

  modport slave (
    input  A,
    input  B,
    input  in_valid,
    output sum,
    output out_valid
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell used as a stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/four_bit_adder.sv
// Registered unsigned adder: ripple-carry chain of full_adder cells into a result register.
module four_bit_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = adder_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  four_bit_adder_if.slave  bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  logic             out_valid_q;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .cin  (carry[i]),
      .s    (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  assign sum_d = {carry[WIDTH], sum_bits};

  // Sum is enabled only by in_valid so garbage operands on idle cycles never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder against an arithmetic reference model.
module tb_four_bit_adder;
  import adder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ref_sum;
  int   ref_valid;

  four_bit_adder_if #(.WIDTH(WIDTH)) bus ();

  four_bit_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sum"}, int'(bus.sum), ref_sum);
    check({tag, ".out_valid"}, int'(bus.out_valid), ref_valid);
  endtask

  // Present one operand pair for one cycle and compare after the capturing edge.
  task automatic apply(input string tag, input int a, input int b, input bit v);
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.in_valid = v;
    @(posedge clk);
    if (v) ref_sum = a + b;
    ref_valid = v ? 1 : 0;
    #1;
    check_outputs(tag);
  endtask

  int seq_a[6] = '{10, 10, 15, 15, 5, 5};
  int seq_b[6] = '{13, 7, 7, 1, 1, 2};
  int cor_a[4] = '{0, 15, 8, 15};
  int cor_b[4] = '{0, 15, 8, 0};

  initial begin
    checks       = 0;
    errors       = 0;
    ref_sum      = 0;
    ref_valid    = 0;
    rst_n        = 1'b0;
    bus.A        = 4'd2;
    bus.B        = 4'd13;
    bus.in_valid = 1'b1;

    #1;
    check_outputs("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    #3;
    rst_n = 1'b1;
    apply("reset_release", 2, 13, 1'b1);
    check("reset_release_const", int'(bus.sum), 15);

    for (int i = 0; i < 6; i++) apply("sequence", seq_a[i], seq_b[i], 1'b1);

    for (int i = 0; i < 4; i++) apply("corner", cor_a[i], cor_b[i], 1'b1);
    check("corner_last_const", int'(bus.sum), 15);

    apply("hold_seed", 7, 8, 1'b1);
    repeat (3) apply("hold", 15, 15, 1'b0);
    check("hold_const", int'(bus.sum), 15);

    apply("midreset_seed", 9, 4, 1'b1);
    #3;
    rst_n = 1'b0;
    ref_sum   = 0;
    ref_valid = 0;
    #1;
    check_outputs("midreset");
    #2;
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) apply("exhaustive", a, b, 1'b1);
    end

    for (int i = 0; i < 200; i++) begin
      apply("random", int'($urandom_range(15)), int'($urandom_range(15)),
            bit'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
